// File: rtl/usb_rx_sink.sv
// Receive end of the USB test-transmitter byte handshake: counts bytes, runs the USB CRC16 check
// and reports length/CRC/overflow once per packet. Define USB_RX_THROTTLE_EN to add periodic stalls.
module usb_rx_sink #(
   parameter int MAX_LEN      = 64,
   parameter int LEN_W        = 7,
   parameter int THROTTLE_N   = 4,
   parameter int THROTTLE_GAP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
   input  logic             tx_last,
   output logic             tx_ready,
   output logic             pkt_done,
   output logic [LEN_W-1:0] pkt_len,
   output logic             crc_ok,
   output logic             overflow,
   output logic [9:0]       hist
);

   localparam int              CNT_W   = $clog2(MAX_LEN + 4);
   localparam logic [CNT_W-1:0] OVF_LIM = CNT_W'(MAX_LEN + 2);
   localparam logic [15:0]     CRC_INIT = 16'hFFFF;
   localparam logic [15:0]     CRC_RES  = 16'hB001;

   if ((1 << LEN_W) <= MAX_LEN || THROTTLE_N < 1 || THROTTLE_GAP < 1) begin : g_bad_cfg
      $error("usb_rx_sink: LEN_W too narrow for MAX_LEN or throttle settings below 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      DRAIN,
`ifdef USB_RX_THROTTLE_EN
      WAIT,
`endif
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      crc;

`ifdef USB_RX_THROTTLE_EN
   localparam int THR_W = $clog2(THROTTLE_N + 1);
   localparam int GAP_W = $clog2(THROTTLE_GAP + 1);
   logic [THR_W-1:0] thr_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [THR_W-1:0] thr_inc;
   assign thr_inc = thr_cnt + 1'b1;
`endif

   // Reflected CRC16 (poly 0xA001), one byte, LSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      // NOTE: blocking '=' is correct here: r is a combinational temporary, rewritten in order.
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction

   logic             accept;
   logic [15:0]      crc_upd;
   logic [CNT_W-1:0] cnt_inc;
   logic             fin_ovf;
   logic [LEN_W-1:0] res_len;
   logic             res_ok;

   // Result of the packet if the beat being accepted now turns out to be its last.
   always_comb begin
      accept  = tx_valid & tx_ready;
      crc_upd = crc16_byte(crc, tx_data);
      cnt_inc = cnt + 1'b1;
      fin_ovf = cnt_inc > OVF_LIM;
      res_len = '0;
      if (fin_ovf)
         res_len = LEN_W'(MAX_LEN);
      else if (cnt_inc >= CNT_W'(2))
         res_len = LEN_W'(cnt_inc - CNT_W'(2));
      res_ok = !fin_ovf && (cnt_inc >= CNT_W'(2)) && (crc_upd == CRC_RES);
   end

   // NOTE: asynchronous active-low reset; every register (outputs included) has a defined reset value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         crc      <= CRC_INIT;
         tx_ready <= 1'b0;
         pkt_done <= 1'b0;
         pkt_len  <= '0;
         crc_ok   <= 1'b0;
         overflow <= 1'b0;
         hist     <= '0;
`ifdef USB_RX_THROTTLE_EN
         thr_cnt  <= '0;
         gap_cnt  <= '0;
`endif
      end else begin
         // NOTE: non-blocking '<=' for all state; later assignments in this block override defaults.
         tx_ready <= 1'b1;
         pkt_done <= 1'b0;
         hist     <= {hist[8:0], accept};
         case (state)
            IDLE, RECV: begin
               if (accept) begin
                  crc <= crc_upd;
                  cnt <= cnt_inc;
                  if (tx_last || fin_ovf) begin
                     if (!tx_last) begin
                        state <= DRAIN;
                     end else begin
                        state    <= DONE;
                        tx_ready <= 1'b0;
                        pkt_done <= 1'b1;
                        pkt_len  <= res_len;
                        crc_ok   <= res_ok;
                        overflow <= fin_ovf;
                     end
                  end
`ifdef USB_RX_THROTTLE_EN
                  else if (thr_inc == THR_W'(THROTTLE_N)) begin
                     state    <= WAIT;
                     tx_ready <= 1'b0;
                     thr_cnt  <= '0;
                  end else begin
                     state   <= RECV;
                     thr_cnt <= thr_inc;
                  end
`else
                  else begin
                     state <= RECV;
                  end
`endif
               end
            end
            DRAIN: begin
               // Overflowed packet: swallow the rest, count and CRC stay frozen.
               if (accept && tx_last) begin
                  state    <= DONE;
                  tx_ready <= 1'b0;
                  pkt_done <= 1'b1;
                  pkt_len  <= LEN_W'(MAX_LEN);
                  crc_ok   <= 1'b0;
                  overflow <= 1'b1;
               end
            end
`ifdef USB_RX_THROTTLE_EN
            WAIT: begin
               if (gap_cnt == GAP_W'(THROTTLE_GAP - 1)) begin
                  state   <= RECV;
                  gap_cnt <= '0;
               end else begin
                  tx_ready <= 1'b0;
                  gap_cnt  <= gap_cnt + 1'b1;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
               crc   <= CRC_INIT;
`ifdef USB_RX_THROTTLE_EN
               thr_cnt <= '0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_rx_sink.sv
// Self-checking bench for usb_rx_sink: vector table plus hand-written corner sequences,
// packet results checked through a scoreboard queue popped on pkt_done.
module tb_usb_rx_sink;

   localparam int MAX_LEN = 64;
   localparam int LEN_W   = 7;

   logic             clk = 1'b0;
   logic             reset;
   logic             tx_valid;
   logic [7:0]       tx_data;
   logic             tx_last;
   logic             tx_ready;
   logic             pkt_done;
   logic [LEN_W-1:0] pkt_len;
   logic             crc_ok;
   logic             overflow;
   logic [9:0]       hist;

   usb_rx_sink #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .THROTTLE_N(4), .THROTTLE_GAP(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .pkt_done (pkt_done),
      .pkt_len  (pkt_len),
      .crc_ok   (crc_ok),
      .overflow (overflow),
      .hist     (hist)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      int  len;
      bit  ok;
      bit  ovf;
   } res_t;
   typedef struct {
      int         n;
      logic [7:0] d[8];
      int         mode;     // 0 raw bytes, 1 append good CRC, 2 append corrupted CRC
      int         exp_len;
      bit         exp_ok;
   } vec_t;

   res_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Bit-serial reference CRC16/USB over a byte stream.
   function automatic logic [15:0] crc_model(input byte_q_t q);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (q[k]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ q[k][b];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
         end
      end
      return c;
   endfunction

   function automatic byte_q_t with_crc(input byte_q_t p, input bit corrupt);
      logic [15:0] c;
      c = ~crc_model(p);
      if (corrupt) c = c ^ 16'h0100;
      p.push_back(c[7:0]);
      p.push_back(c[15:8]);
      return p;
   endfunction

   // Scoreboard consumer.
   always @(negedge clk) begin
      if (reset && pkt_done) begin
         n_done++;
         if (sb.size() == 0) begin
            fail_now("unexpected_pkt_done");
         end else begin
            res_t e;
            e = sb.pop_front();
            check("pkt_len", 32'(pkt_len), 32'(e.len));
            check("crc_ok", 32'(crc_ok), 32'(e.ok));
            check("overflow", 32'(overflow), 32'(e.ovf));
         end
      end
   end

   task automatic send_pkt(input byte_q_t q, input int gap, input bit close, input res_t exp,
                           output int cycles, output int stalls, output logic [9:0] h_done);
      bit acc;
      cycles = 0;
      stalls = 0;
      h_done = '0;
      for (int i = 0; i < q.size(); i++) begin
         if (i > 0) begin
            repeat (gap) begin
               tx_valid = 1'b0;
               @(posedge clk); #1;
               cycles++;
            end
         end
         tx_valid = 1'b1;
         tx_data  = q[i];
         tx_last  = close && (i == q.size() - 1);
         if (tx_last) sb.push_back(exp);
         acc = 1'b0;
         for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = tx_ready;
            if (!acc) stalls++;
            @(posedge clk); #1;
            cycles++;
         end
         if (!acc) begin
            fail_now("accept_timeout");
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            return;
         end
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = 8'h00;
      if (close) begin
         check("done_latency", 32'(pkt_done), 32'd1);
         check("ready_low_in_done", 32'(tx_ready), 32'd0);
         h_done = hist;
         cycles++;
         @(posedge clk); #1;
         check("done_one_cycle", 32'(pkt_done), 32'd0);
         check("ready_after_done", 32'(tx_ready), 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      vec_t        vecs[7];
      byte_q_t     q;
      res_t        r;
      int          cyc_n, st, done0;
      logic [9:0]  h;

      vecs[0] = '{2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1'b1};
      vecs[1] = '{2, '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1'b0};
      vecs[2] = '{1, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1'b0};
      vecs[3] = '{3, '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 3, 1'b1};
      vecs[4] = '{8, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'hFF, 8'h55, 8'hAA}, 1, 8, 1'b1};
      vecs[5] = '{4, '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 4, 1'b0};
      vecs[6] = '{1, '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1, 1'b1};

      reset    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_pkt_done", 32'(pkt_done), 32'd0);
      check("rst_pkt_len", 32'(pkt_len), 32'd0);
      check("rst_crc_ok", 32'(crc_ok), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_hist", 32'(hist), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("ready_after_release", 32'(tx_ready), 32'd1);

      // Table-driven packets, alternating back-to-back and gapped beats.
      for (int i = 0; i < 7; i++) begin
         q = {};
         for (int k = 0; k < vecs[i].n; k++) q.push_back(vecs[i].d[k]);
         if (vecs[i].mode != 0) q = with_crc(q, vecs[i].mode == 2);
         r = '{vecs[i].exp_len, vecs[i].exp_ok, 1'b0};
         send_pkt(q, i % 2, 1'b1, r, cyc_n, st, h);
      end

      // Gapped valid over the zero-length packet.
      q = {8'h00, 8'h00};
      send_pkt(q, 1, 1'b1, '{0, 1'b1, 1'b0}, cyc_n, st, h);
      check("gapped_hist", 32'(h[2:0]), 32'b101);

      // Throttle timing on an 8-byte stream with valid held.
      q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      q = with_crc(q, 1'b0);
      send_pkt(q, 0, 1'b1, '{6, 1'b1, 1'b0}, cyc_n, st, h);
`ifdef USB_RX_THROTTLE_EN
      check("throttle_cycles", 32'(cyc_n), 32'd11);
      check("throttle_stalls", 32'(st), 32'd2);
`else
      check("stream_cycles", 32'(cyc_n), 32'd9);
      check("stream_stalls", 32'(st), 32'd0);
`endif

      // Largest legal payload plus CRC, then results must hold while idle.
      q = {};
      for (int k = 0; k < MAX_LEN; k++) q.push_back(8'(k * 7 + 3));
      q = with_crc(q, 1'b0);
      send_pkt(q, 0, 1'b1, '{MAX_LEN, 1'b1, 1'b0}, cyc_n, st, h);
      repeat (3) @(posedge clk);
      #1;
      check("hold_pkt_len", 32'(pkt_len), 32'(MAX_LEN));
      check("hold_crc_ok", 32'(crc_ok), 32'd1);
      check("hold_pkt_done", 32'(pkt_done), 32'd0);

      // Overflow threshold and tx_last on the same beat.
      q = {};
      for (int k = 0; k < MAX_LEN + 3; k++) q.push_back(8'(k));
      done0 = n_done;
      send_pkt(q, 0, 1'b1, '{MAX_LEN, 1'b0, 1'b1}, cyc_n, st, h);
      check("ovf_tie_done_count", 32'(n_done - done0), 32'd1);

      // Overflow with two drained beats after the threshold.
      q = {};
      for (int k = 0; k < MAX_LEN + 5; k++) q.push_back(8'(255 - k));
      done0 = n_done;
      send_pkt(q, 0, 1'b1, '{MAX_LEN, 1'b0, 1'b1}, cyc_n, st, h);
      check("ovf_done_count", 32'(n_done - done0), 32'd1);

      // Reset mid-packet: partial packet is dropped, next packet is clean.
      q = {8'h12, 8'h34, 8'h56};
      send_pkt(q, 0, 1'b0, '{0, 1'b0, 1'b0}, cyc_n, st, h);
      reset = 1'b0;
      #1;
      check("midrst_hist", 32'(hist), 32'd0);
      check("midrst_tx_ready", 32'(tx_ready), 32'd0);
      check("midrst_pkt_len", 32'(pkt_len), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      done0 = n_done;
      q = {8'h00, 8'h00};
      send_pkt(q, 0, 1'b1, '{0, 1'b1, 1'b0}, cyc_n, st, h);
      check("midrst_done_count", 32'(n_done - done0), 32'd1);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_rx_sink.md
Name: usb_rx_sink

Overview:
- Receive end of the tx_valid/tx_ready byte handshake used by the USB test transmitter.
- Accepts a byte stream delimited by tx_last and counts the bytes.
- Runs the USB data CRC16 check over each packet and reports payload length, CRC status and overflow once per packet.
- Keeps a 10-cycle history of accepted beats for debug.

Parameters:
- MAX_LEN, 64, maximum payload bytes per packet (CRC bytes excluded).
- LEN_W, 7, width of pkt_len; must satisfy 2^LEN_W > MAX_LEN.
- THROTTLE_N, 4, accepted beats between forced stalls (used only with USB_RX_THROTTLE_EN).
- THROTTLE_GAP, 2, stall length in cycles (used only with USB_RX_THROTTLE_EN).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  reset, asynchronous, active-low.
- tx_valid  input  1  transmitter has a byte on tx_data.
- tx_data  input  8  byte, USB bit order (LSB first on wire).
- tx_last  input  1  current byte is the final byte of the packet (the second CRC byte).
- tx_ready  output  1  sink accepts a byte this cycle; registered.
- pkt_done  output  1  one-cycle pulse, packet result valid.
- pkt_len  output  LEN_W  payload bytes of the last packet.
- crc_ok  output  1  CRC16 residue matched for the last packet.
- overflow  output  1  last packet exceeded MAX_LEN.
- hist  output  10  accepted-beat history; hist[0] is the newest.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, byte counter 0, CRC register 0xFFFF, throttle counter 0.
  - Reset mid-packet discards the partial packet; no pkt_done is produced for it.
- Beat accepted at a rising edge when tx_valid=1 and tx_ready=1.
  - tx_data and tx_last are ignored on any other cycle.
- tx_ready is registered:
  - goes 1 on the first edge after reset release;
  - is 0 during the DONE cycle and during the WAIT state;
  - is 1 otherwise.
- States:
  - IDLE: tx_ready=1. A beat moves to RECV, or to DONE if tx_last=1. CRC is updated with the byte and the count becomes 1.
  - RECV: each beat updates the CRC and increments the count.
    - A beat with tx_last=1 moves to DONE.
    - When the count exceeds MAX_LEN+2, set the internal overflow flag and move to DRAIN.
    - With the macro enabled, every THROTTLE_N-th beat moves to WAIT.
  - DRAIN: tx_ready=1. Beats are discarded (no CRC update, count frozen). A beat with tx_last=1 moves to DONE.
  - WAIT: tx_ready=0 for exactly THROTTLE_GAP cycles, then RECV. Reachable only with the macro enabled.
  - DONE: lasts exactly one cycle, then IDLE; CRC and count re-initialised for the next packet.
    - pkt_done=1 in this cycle.
    - pkt_len, crc_ok and overflow are updated on entry to DONE and held until the next DONE.
- Latency: last beat accepted at edge N → pkt_done high in the cycle after edge N. Minimum packet-to-packet gap is 1 cycle.
- CRC16 (USB):
  - Reflected polynomial 0xA001, init 0xFFFF, bytes processed LSB first.
  - Covers all accepted bytes including the two CRC bytes.
  - crc_ok=1 iff the final register equals 0xB001, the byte count is ≥2, and overflow=0.
- pkt_len:
  - byte count minus 2, saturating at 0;
  - equals MAX_LEN on overflow.
  - Packets of 0 or 1 bytes give pkt_len=0 and crc_ok=0.
- hist shifts every cycle while out of reset: hist[0] ← accepted beat, hist[9:1] ← hist[8:0].
- Simultaneous tx_last and overflow threshold on the same beat: overflow takes priority; go to DONE with overflow=1 and crc_ok=0.
- Counter width is sufficient for MAX_LEN+3 and never wraps; DRAIN freezes it.

Optional Feature:
- USB_RX_THROTTLE_EN defined: WAIT state enabled. After every THROTTLE_N accepted beats within a packet (DRAIN excluded), tx_ready drops for THROTTLE_GAP cycles. The throttle counter restarts at each packet.
- Not defined: WAIT is not built. tx_ready is 0 only in the DONE cycle. THROTTLE_N and THROTTLE_GAP are unused.

Test Plan:
- Zero-length packet: bytes 0x00, 0x00 (second with tx_last), tx_valid held 1 → pkt_done pulse 1 cycle after the 2nd beat; pkt_len=0, crc_ok=1, overflow=0; tx_ready=0 in that cycle only.
- Corrupted CRC: bytes 0x00, 0x01 → pkt_len=0, crc_ok=0.
- Overflow: MAX_LEN+5 bytes, last flagged → overflow=1, pkt_len=MAX_LEN, crc_ok=0, exactly one pkt_done, after the final tx_last beat.
- Reset mid-packet: 3 bytes accepted, reset pulsed low for 1 cycle, then a 0x00, 0x00 packet → no pkt_done for the partial packet; the second packet reports crc_ok=1; hist=0 immediately after reset.
- Gapped valid: tx_valid pattern 1,0,1 over the 0x00, 0x00 packet → 2 beats accepted, hist[2:0]=3'b101 in the cycle after the second accept (pkt_done cycle), crc_ok=1.
- With USB_RX_THROTTLE_EN (N=4, GAP=2): 8-byte stream with valid held 1 → tx_ready low for 2 cycles after the 4th beat; total cycles = 8 beats + 2 stall + 1 DONE.
